// File: rtl/frame_scheduler_pkg.sv
// Shared constants and FSM state type for the LED-matrix frame scheduler.
// FRAME_BLANK_EN adds the BLANK state used for the inter-frame blank interval.
package frame_scheduler_pkg;

   localparam int unsigned GS_DEF        = 8;
   localparam int unsigned TIMEOUT_DEF   = 40000;
   localparam int unsigned BLANK_CYC_DEF = 256;
   localparam int unsigned WD_W          = 16;

`ifdef FRAME_BLANK_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_RESTART = 2'd2,
      ST_BLANK   = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_RESTART = 2'd2
   } state_e;
`endif

   function automatic int unsigned frame_w(input int unsigned gs);
      return gs * gs;
   endfunction

   // Terminal count for an interval of cyc cycles, counter starting at 0.
   function automatic logic [WD_W-1:0] wd_limit(input int unsigned cyc);
      return (cyc == 0) ? '0 : WD_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/frame_scheduler_scan_watchdog.sv
// Clearable up-counter with terminal-count compare; times both the scan
// watchdog and the inter-frame blank interval.
module scan_watchdog
   import frame_scheduler_pkg::*;
#(
   parameter int unsigned W = WD_W
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc_o = en_i && (count_q == limit_i);

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffered frame scheduler for the LED-matrix scanner: swaps frames at
// frame boundaries, counts frames, and restarts a hung scan via a watchdog.
// Build option FRAME_BLANK_EN: blank the display for BLANK_CYC cycles between frames.
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int unsigned GS        = GS_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
   parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    run_i,
   input  logic [GS*GS-1:0]        frame_i,
   input  logic                    frame_valid_i,
   output logic                    frame_ready_o,
   input  logic                    disp_done_i,
   output logic                    e_disp_o,
   output logic [GS*GS-1:0]        matrix_o,
   output logic                    swap_o,
   output logic [7:0]              frame_cnt_o,
   output logic                    fault_o
);

   localparam int unsigned FW = frame_w(GS);

`ifdef FRAME_BLANK_EN
   localparam state_e GAP_ST = ST_BLANK;
`else
   localparam state_e GAP_ST = ST_RESTART;
`endif

   state_e          state_q, state_d;
   logic [FW-1:0]   front_q, back_q;
   logic            pending_q;
   logic            swap_q;
   logic [7:0]      cnt_q;
   logic            fault_q;
   logic            done_evt, to_evt;
   logic            wd_clr, wd_en, wd_tc;
   logic [WD_W-1:0] wd_lim;
   logic            accept;

   assign accept = frame_valid_i & ~pending_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stopping takes priority over a coincident done or timeout.
   always_comb begin
      state_d  = state_q;
      done_evt = 1'b0;
      to_evt   = 1'b0;
      if (!run_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_SCAN;
            ST_SCAN: begin
               if (disp_done_i) begin
                  done_evt = 1'b1;
                  state_d  = GAP_ST;
               end else if (wd_tc) begin
                  to_evt  = 1'b1;
                  state_d = GAP_ST;
               end
            end
            ST_RESTART: state_d = ST_SCAN;
`ifdef FRAME_BLANK_EN
            ST_BLANK:   if (wd_tc) state_d = ST_SCAN;
`endif
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      e_disp_o = (state_q == ST_SCAN);
`ifdef FRAME_BLANK_EN
      wd_en    = (state_q == ST_SCAN) || (state_q == ST_BLANK);
`else
      wd_en    = (state_q == ST_SCAN);
`endif
      wd_clr   = (state_d != state_q);
      wd_lim   = (state_q == ST_SCAN) ? wd_limit(TIMEOUT) : wd_limit(BLANK_CYC);
   end

   scan_watchdog #(
      .W (WD_W)
   ) u_wd (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (wd_clr),
      .en_i    (wd_en),
      .limit_i (wd_lim),
      .tc_o    (wd_tc)
   );

   // A swap needs pending=1, so it never coincides with an accept.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         front_q   <= '0;
         back_q    <= '0;
         pending_q <= 1'b0;
         swap_q    <= 1'b0;
         cnt_q     <= '0;
         fault_q   <= 1'b0;
      end else begin
         swap_q <= done_evt & pending_q;
         if (done_evt && pending_q) begin
            front_q <= back_q;
         end
         if (accept) begin
            back_q    <= frame_i;
            pending_q <= 1'b1;
         end else if (done_evt) begin
            pending_q <= 1'b0;
         end
         if (done_evt) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (to_evt) begin
            fault_q <= 1'b1;
         end
      end
   end

   assign frame_ready_o = ~pending_q;
   assign matrix_o      = front_q;
   assign swap_o        = swap_q;
   assign frame_cnt_o   = cnt_q;
   assign fault_o       = fault_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed vector table, hand-written
// timeout/reset/wrap sequences and randomized traffic against a reference model.
module tb_frame_scheduler;

   localparam int GS  = 8;
   localparam int FW  = GS * GS;
   localparam int TMO = 50;
   localparam int BLK = 4;
`ifdef FRAME_BLANK_EN
   localparam int GAP = BLK;
`else
   localparam int GAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          valid = 1'b0;
   logic          done = 1'b0;
   logic [FW-1:0] frame = '0;
   logic          ready, e_disp, swap, fault;
   logic [FW-1:0] matrix;
   logic [7:0]    cnt;

   int total = 0;
   int bad   = 0;

   frame_scheduler #(
      .GS        (GS),
      .TIMEOUT   (TMO),
      .BLANK_CYC (BLK)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .run_i         (run),
      .frame_i       (frame),
      .frame_valid_i (valid),
      .frame_ready_o (ready),
      .disp_done_i   (done),
      .e_disp_o      (e_disp),
      .matrix_o      (matrix),
      .swap_o        (swap),
      .frame_cnt_o   (cnt),
      .fault_o       (fault)
   );

   always #5 clk = ~clk;

   // Reference model: display is either scanning, in a low gap of m_gap
   // remaining cycles, or stopped; buffers tracked as plain values.
   bit            m_en, m_pend, m_swap, m_fault;
   int            m_gap, m_age, m_cnt;
   logic [FW-1:0] m_front, m_back;

   task automatic model_reset();
      m_en = 0; m_pend = 0; m_swap = 0; m_fault = 0;
      m_gap = 0; m_age = 0; m_cnt = 0;
      m_front = '0; m_back = '0;
   endtask

   task automatic model_step();
      bit acc;
      acc    = valid && !m_pend;
      m_swap = 0;
      if (!run) begin
         m_en = 0; m_gap = 0; m_age = 0;
      end else if (m_en) begin
         if (done) begin
            m_cnt = (m_cnt + 1) % 256;
            if (m_pend) begin
               m_front = m_back; m_pend = 0; m_swap = 1;
            end
            m_en = 0; m_gap = GAP; m_age = 0;
         end else if (m_age == TMO - 1) begin
            m_fault = 1; m_en = 0; m_gap = GAP; m_age = 0;
         end else begin
            m_age++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) m_en = 1;
      end else begin
         m_en = 1;
      end
      if (acc) begin
         m_back = frame; m_pend = 1;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("e_disp", 64'(e_disp), 64'(m_en));
      chk("ready",  64'(ready),  64'(!m_pend));
      chk("swap",   64'(swap),   64'(m_swap));
      chk("cnt",    64'(cnt),    64'(m_cnt));
      chk("matrix", 64'(matrix), 64'(m_front));
      chk("fault",  64'(fault),  64'(m_fault));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   typedef struct {
      bit            run, valid, done;
      logic [FW-1:0] frame;
      int            cyc;
      bit            en, rdy, swp;
      int            cnt;
      logic [FW-1:0] mat;
   } vec_t;

   vec_t tv[19];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [FW-1:0] fa, fb, fc, fd;
      fa = 64'h0000_0000_0000_00FF;
      fb = 64'h5A5A_0000_1234_FFFF;
      fc = 64'hC3C3_C3C3_0F0F_0F0F;
      fd = 64'h8000_0000_0000_0001;
      //        run valid done frame cyc  en rdy swp cnt mat
      tv[0]  = '{1, 1, 0, fa,  1,   1, 0, 0, 0, '0};
      tv[1]  = '{1, 0, 0, '0,  1,   1, 0, 0, 0, '0};
      tv[2]  = '{1, 0, 1, '0,  1,   0, 1, 1, 1, fa};
      tv[3]  = '{1, 0, 0, '0,  GAP, 1, 1, 0, 1, fa};
      tv[4]  = '{1, 1, 0, fb,  1,   1, 0, 0, 1, fa};
      tv[5]  = '{1, 1, 0, fc,  1,   1, 0, 0, 1, fa};
      tv[6]  = '{1, 0, 1, '0,  1,   0, 1, 1, 2, fb};
      tv[7]  = '{1, 1, 0, fc,  GAP, 1, 0, 0, 2, fb};
      tv[8]  = '{1, 0, 1, '0,  1,   0, 1, 1, 3, fc};
      tv[9]  = '{1, 0, 0, '0,  GAP, 1, 1, 0, 3, fc};
      tv[10] = '{1, 1, 1, fd,  1,   0, 0, 0, 4, fc};
      tv[11] = '{1, 0, 0, '0,  GAP, 1, 0, 0, 4, fc};
      tv[12] = '{1, 0, 1, '0,  1,   0, 1, 1, 5, fd};
      tv[13] = '{0, 0, 0, '0,  1,   0, 1, 0, 5, fd};
      tv[14] = '{0, 0, 1, '0,  1,   0, 1, 0, 5, fd};
      tv[15] = '{1, 0, 0, '0,  1,   1, 1, 0, 5, fd};
      tv[16] = '{0, 0, 0, '0,  1,   0, 1, 0, 5, fd};
      tv[17] = '{0, 0, 1, '0,  1,   0, 1, 0, 5, fd};
      tv[18] = '{1, 0, 0, '0,  1,   1, 1, 0, 5, fd};

      model_reset();
      #2;
      check_all();
      #10 rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         run = tv[i].run; valid = tv[i].valid; done = tv[i].done; frame = tv[i].frame;
         for (int k = 0; k < tv[i].cyc; k++) tick();
         chk($sformatf("tv%0d_en", i),  64'(e_disp), 64'(tv[i].en));
         chk($sformatf("tv%0d_rdy", i), 64'(ready),  64'(tv[i].rdy));
         chk($sformatf("tv%0d_swp", i), 64'(swap),   64'(tv[i].swp));
         chk($sformatf("tv%0d_cnt", i), 64'(cnt),    64'(tv[i].cnt));
         chk($sformatf("tv%0d_mat", i), 64'(matrix), 64'(tv[i].mat));
      end

      // Watchdog: scanning with no done for TMO cycles.
      run = 1; valid = 0; done = 0;
      repeat (TMO - 1) tick();
      chk("wd_pre_en", 64'(e_disp), 64'd1);
      chk("wd_pre_fault", 64'(fault), 64'd0);
      tick();
      chk("wd_fire_en", 64'(e_disp), 64'd0);
      chk("wd_fire_fault", 64'(fault), 64'd1);
      chk("wd_fire_cnt", 64'(cnt), 64'd5);
      repeat (GAP) tick();
      chk("wd_resume_en", 64'(e_disp), 64'd1);
      done = 1;
      tick();
      done = 0;
      chk("wd_sticky_fault", 64'(fault), 64'd1);
      chk("wd_done_cnt", 64'(cnt), 64'd6);

      // Asynchronous reset in the middle of a scan.
      repeat (GAP) tick();
      chk("pre_rst_en", 64'(e_disp), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_e_disp", 64'(e_disp), 64'd0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // 256 completed frames wrap the counter back to zero.
      run = 1; valid = 0; done = 0;
      for (int i = 0; i < 256; i++) begin
         for (int g = 0; g < GAP + 3 && !m_en; g++) tick();
         done = 1;
         tick();
         done = 0;
         if (i == 254) chk("wrap_255", 64'(cnt), 64'd255);
      end
      chk("wrap_0", 64'(cnt), 64'd0);

      // Randomized traffic; producer holds an offered frame until it is taken.
      for (int i = 0; i < 3000; i++) begin
         run  = ($urandom_range(0, 19) != 0);
         done = ($urandom_range(0, 11) == 0);
         if (!(valid && m_pend)) begin
            valid = ($urandom_range(0, 2) == 0);
            frame = {$urandom, $urandom};
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
